// File: rtl/coin_pkg.sv
// coin_pkg
// Shared definitions for the coin pulse generator:
//   state_t   - arbitration FSM encoding (IDLE waits for a press, HOLD waits
//               for every button to be released)
//   TALLY_W   - width of the optional coin tally counters
//   TALLY_MAX - saturation value of the tally counters
//   sat_inc   - saturating increment used by the tally counters
package coin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int TALLY_W = 8;
  localparam logic [TALLY_W-1:0] TALLY_MAX = 8'd255;

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] value);
    return (value == TALLY_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// debounce_filter
// Synchronizes one raw, bouncy button input into the clk domain and filters it
// so the output level only changes after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles required to accept a change (minimum 2)
// Ports:
//   clk   - system clock
//   rst   - asynchronous, active-high reset
//   raw   - raw button input, asynchronous to clk
//   level - debounced button level
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // The counter holds the number of consecutive cycles the synchronized input
  // has disagreed with the accepted level; the edge that would make it reach
  // DEBOUNCE_CYCLES accepts the new level instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coin_pulse_gen.sv
// coin_pulse_gen
// Turns raw nickel/dime buttons into clean single-cycle nb/db pulses for the
// vending FSM: one coin per press, one coin at a time, none while vending.
// Optional build macro: COIN_TALLY_EN adds saturating coin tally counters.
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles required to accept a level change (min 2)
// Ports:
//   clk          - system clock
//   rst          - asynchronous, active-high reset
//   nickel_btn   - raw nickel button
//   dime_btn     - raw dime button
//   inhibit      - high while the FSM is dispensing; presses are consumed
//   tally_clr    - (COIN_TALLY_EN) synchronous clear of both tallies
//   nickel_count - (COIN_TALLY_EN) accepted nickels, saturating at 255
//   dime_count   - (COIN_TALLY_EN) accepted dimes, saturating at 255
//   nb           - one-cycle nickel pulse
//   db           - one-cycle dime pulse
//   busy         - high while a press is being waited out
module coin_pulse_gen
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nickel_btn,
  input  logic               dime_btn,
  input  logic               inhibit,
`ifdef COIN_TALLY_EN
  input  logic               tally_clr,
  output logic [TALLY_W-1:0] nickel_count,
  output logic [TALLY_W-1:0] dime_count,
`endif
  output logic               nb,
  output logic               db,
  output logic               busy
);

  logic   nickel_lvl;
  logic   dime_lvl;
  logic   nickel_lvl_d1;
  logic   dime_lvl_d1;
  logic   rise_nickel;
  logic   rise_dime;
  state_t state;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_nickel_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (nickel_btn),
    .level (nickel_lvl)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dime_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (dime_btn),
    .level (dime_lvl)
  );

  // Rise flags are registered, so each is a one-cycle strobe one cycle after
  // the debounced level goes high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nickel_lvl_d1 <= 1'b0;
      dime_lvl_d1   <= 1'b0;
      rise_nickel   <= 1'b0;
      rise_dime     <= 1'b0;
    end else begin
      nickel_lvl_d1 <= nickel_lvl;
      dime_lvl_d1   <= dime_lvl;
      rise_nickel   <= nickel_lvl & ~nickel_lvl_d1;
      rise_dime     <= dime_lvl & ~dime_lvl_d1;
    end
  end

  // Any rise seen in IDLE moves to HOLD, whether or not it produced a pulse;
  // that is what consumes inhibited presses and drops the losing nickel of a
  // simultaneous press. Dime has priority when both rise together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      nb    <= 1'b0;
      db    <= 1'b0;
    end else begin
      nb <= 1'b0;
      db <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_nickel || rise_dime) begin
            state <= HOLD;
            if (!inhibit) begin
              if (rise_dime) begin
                db <= 1'b1;
              end else begin
                nb <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (!nickel_lvl && !dime_lvl) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == HOLD);

`ifdef COIN_TALLY_EN
  // Tallies count the cycle a pulse is high; a clear in that same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nickel_count <= '0;
      dime_count   <= '0;
    end else if (tally_clr) begin
      nickel_count <= '0;
      dime_count   <= '0;
    end else begin
      if (nb) begin
        nickel_count <= sat_inc(nickel_count);
      end
      if (db) begin
        dime_count <= sat_inc(dime_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_coin_pulse_gen.sv
// tb_coin_pulse_gen
// Directed bench for coin_pulse_gen with DEBOUNCE_CYCLES=4. Every expected
// pulse (kind and cycle) is queued when a press is driven; a negedge monitor
// pops and compares each pulse the DUT emits.
module tb_coin_pulse_gen;

  localparam int DEB = 4;
  // Input changed between edges at cycle c: edge c+1 samples it, and the
  // pulse is visible after edge c+1 + 2 + DEB + 1.
  localparam int LAT = 1 + 2 + DEB + 1;

  typedef struct {
    bit is_dime;
    int cycle;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nickel_btn = 1'b0;
  logic dime_btn = 1'b0;
  logic inhibit = 1'b0;
  logic nb;
  logic db;
  logic busy;
`ifdef COIN_TALLY_EN
  logic       tally_clr = 1'b0;
  logic [7:0] nickel_count;
  logic [7:0] dime_count;
`endif

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  pulse_t exp_q[$];

  coin_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .nickel_btn   (nickel_btn),
    .dime_btn     (dime_btn),
    .inhibit      (inhibit),
`ifdef COIN_TALLY_EN
    .tally_clr    (tally_clr),
    .nickel_count (nickel_count),
    .dime_count   (dime_count),
`endif
    .nb           (nb),
    .db           (db),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic nickel, input logic dime);
    nickel_btn = nickel;
    dime_btn   = dime;
  endtask

  task automatic expectPulse(input bit is_dime);
    pulse_t p;
    p.is_dime = is_dime;
    p.cycle   = cyc + LAT;
    exp_q.push_back(p);
  endtask

  // Pulse monitor: every high cycle of nb/db must match the next queued pulse.
  always @(negedge clk) begin : monitor
    pulse_t p;
    if (nb === 1'b1 || db === 1'b1) begin
      checkOutput("pulse_exclusive", 32'(nb & db), 32'd0);
      checkOutput("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        checkOutput("pulse_kind_is_dime", 32'(db), 32'(p.is_dime));
        checkOutput("pulse_cycle", 32'(cyc), 32'(p.cycle));
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    checkOutput("reset_nb", 32'(nb), 32'd0);
    checkOutput("reset_db", 32'(db), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(2);

    // Clean nickel press
    applyStimulus(1'b1, 1'b0);
    expectPulse(1'b0);
    tick(20);
    checkOutput("nickel_held_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("nickel_released_busy", 32'(busy), 32'd0);
    checkOutput("nickel_drained", 32'(exp_q.size()), 32'd0);

    // Bouncy dime: three 3-cycle highs split by 1-cycle lows, then stable
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      tick(3);
      applyStimulus(1'b0, 1'b0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b1);
    expectPulse(1'b1);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("bouncy_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous press: dime wins, nickel dropped; re-pressed nickel counts
    applyStimulus(1'b1, 1'b1);
    expectPulse(1'b1);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    applyStimulus(1'b1, 1'b0);
    expectPulse(1'b0);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("simul_drained", 32'(exp_q.size()), 32'd0);

    // Press during inhibit is consumed even after inhibit drops
    inhibit = 1'b1;
    applyStimulus(1'b0, 1'b1);
    tick(20);
    checkOutput("inhibit_busy", 32'(busy), 32'd1);
    inhibit = 1'b0;
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("inhibit_release_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1);
    expectPulse(1'b1);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("inhibit_drained", 32'(exp_q.size()), 32'd0);

    // Dime pressed while nickel still held is ignored
    applyStimulus(1'b1, 1'b0);
    expectPulse(1'b0);
    tick(12);
    applyStimulus(1'b1, 1'b1);
    tick(20);
    checkOutput("second_press_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    applyStimulus(1'b0, 1'b1);
    expectPulse(1'b1);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("second_press_drained", 32'(exp_q.size()), 32'd0);

    // Button held through reset release gives exactly one pulse
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("held_reset_nb", 32'(nb), 32'd0);
    rst = 1'b0;
    expectPulse(1'b0);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("held_reset_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-debounce loses the count; debounce restarts from scratch
    applyStimulus(1'b1, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(2);
    checkOutput("mid_debounce_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    expectPulse(1'b0);
    tick(20);
    applyStimulus(1'b0, 1'b0);
    tick(12);
    checkOutput("mid_debounce_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-pulse cuts the pulse immediately
    applyStimulus(1'b1, 1'b0);
    expectPulse(1'b0);
    tick(LAT);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_pulse_nb", 32'(nb), 32'd0);
    checkOutput("mid_pulse_busy", 32'(busy), 32'd0);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    tick(12);
    checkOutput("mid_pulse_drained", 32'(exp_q.size()), 32'd0);

`ifdef COIN_TALLY_EN
    // Tally counters: reset, saturation, clear coincident with a pulse
    rst = 1'b1;
    tick(2);
    checkOutput("tally_reset_nickel", 32'(nickel_count), 32'd0);
    checkOutput("tally_reset_dime", 32'(dime_count), 32'd0);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0);
      expectPulse(1'b0);
      tick(10);
      if (i == 0) begin
        checkOutput("tally_first_nickel", 32'(nickel_count), 32'd1);
      end
      applyStimulus(1'b0, 1'b0);
      tick(8);
    end
    checkOutput("tally_nickel_saturated", 32'(nickel_count), 32'd255);
    checkOutput("tally_dime_untouched", 32'(dime_count), 32'd0);
    applyStimulus(1'b0, 1'b1);
    expectPulse(1'b1);
    tick(10);
    checkOutput("tally_dime_one", 32'(dime_count), 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick(8);
    applyStimulus(1'b1, 1'b0);
    expectPulse(1'b0);
    tick(LAT);
    tally_clr = 1'b1;
    tick(1);
    tally_clr = 1'b0;
    tick(1);
    checkOutput("tally_clr_wins_nickel", 32'(nickel_count), 32'd0);
    checkOutput("tally_clr_wins_dime", 32'(dime_count), 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick(8);
    checkOutput("tally_drained", 32'(exp_q.size()), 32'd0);
`endif

    checkOutput("final_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
